// File: rtl/bit_scan_pkg.sv
// Shared FSM state encoding for the bit scan encoder.
package bit_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_NONE = 2'd2;

endpackage

// File: rtl/ffs_encoder.sv
// Combinational first-set-bit finder; MSB_FIRST picks the scan direction.
module ffs_encoder #(
  parameter int SZY       = 3,
  parameter int SZX       = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [SZX-1:0] vec,
  output logic [SZY-1:0] idx,
  output logic           hit
);

  // Later loop iterations win, so iterate away from the preferred end.
  // Only indices 0..SZX-1 are ever produced, whatever SZX is.
  always_comb begin
    idx = '0;
    hit = |vec;
    for (int i = 0; i < SZX; i++) begin
      if (MSB_FIRST) begin
        if (vec[i]) idx = SZY'(i);
      end else begin
        if (vec[SZX-1-i]) idx = SZY'(SZX-1-i);
      end
    end
  end

endmodule

// File: rtl/bit_scan_encoder.sv
// Captures a bit vector and streams out the index of each set bit, one beat
// per cycle, with a single out_none beat for an all-zero vector.
module bit_scan_encoder
  import bit_scan_pkg::*;
#(
  parameter int SZX       = 8,
  parameter int SZY       = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [SZX-1:0] in_vec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SZY-1:0] out_idx,
  output logic           out_last,
  output logic           out_none,
  output logic [SZY:0]   hit_cnt,
  output logic           busy
);

  localparam logic [SZX-1:0] ONE = SZX'(1);

  state_t         state;
  logic [SZX-1:0] residue;
  logic [SZY:0]   hit_q;
  logic [SZY-1:0] ffs_idx;
  logic           ffs_hit;
  logic           single;
  logic           fire;
  logic           accept;
  logic [SZX-1:0] residue_clr;

  function automatic logic [SZY:0] popcnt(input logic [SZX-1:0] v);
    popcnt = '0;
    for (int i = 0; i < SZX; i++) popcnt = popcnt + (SZY+1)'(v[i]);
  endfunction

  ffs_encoder #(
    .SZY      (SZY),
    .SZX      (SZX),
    .MSB_FIRST(MSB_FIRST)
  ) u_ffs (
    .vec(residue),
    .idx(ffs_idx),
    .hit(ffs_hit)
  );

  // Exactly one bit left means clearing the lowest set bit empties the residue.
  assign single      = ffs_hit & ((residue & (residue - ONE)) == '0);
  assign residue_clr = residue & ~(ONE << ffs_idx);

  assign out_valid = (state == ST_SCAN) | (state == ST_NONE);
  assign out_idx   = (state == ST_SCAN) ? ffs_idx : '0;
  assign out_last  = (state == ST_SCAN) ? single : (state == ST_NONE);
  assign out_none  = (state == ST_NONE);
  assign busy      = (state != ST_IDLE);
  assign hit_cnt   = hit_q;

  assign fire     = out_valid & out_ready;
  assign in_ready = (state == ST_IDLE) | (fire & out_last);
  assign accept   = in_valid & in_ready;

  // Accept takes priority over the retiring beat so the final handoff
  // reloads the residue with no idle bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      residue <= '0;
      hit_q   <= '0;
    end else if (accept) begin
      residue <= in_vec;
      hit_q   <= popcnt(in_vec);
      state   <= (|in_vec) ? ST_SCAN : ST_NONE;
    end else if (fire) begin
      if (state == ST_SCAN) residue <= residue_clr;
      if (out_last) state <= ST_IDLE;
    end else if (!out_valid && state != ST_IDLE) begin
      state <= ST_IDLE;
    end
  end

endmodule
